// File: rtl/dataproc_pkg.sv
// Shared pixel-path definitions for the dataproc window generator and processing core.
// Holds pixel/window widths, the frame-tracking state encoding and the window packing helper.
package dataproc_pkg;

  localparam int PIX_W = 8;
  localparam int WIN_W = 72;
  localparam int COL_W = 3 * PIX_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // A column holds rows r-2 (low byte) .. r (high byte); window byte 3*i+j is row i of column j.
  function automatic logic [WIN_W-1:0] pack_window(input logic [COL_W-1:0] col0,
                                                   input logic [COL_W-1:0] col1,
                                                   input logic [COL_W-1:0] col2);
    logic [WIN_W-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++) begin
      w[PIX_W*(3*i+0) +: PIX_W] = col0[PIX_W*i +: PIX_W];
      w[PIX_W*(3*i+1) +: PIX_W] = col1[PIX_W*i +: PIX_W];
      w[PIX_W*(3*i+2) +: PIX_W] = col2[PIX_W*i +: PIX_W];
    end
    return w;
  endfunction

endpackage

// File: rtl/dataproc_linebuf_row.sv
// One image row of pixel storage: asynchronous read, synchronous write.
// Read and write share one address so a slot can be read and replaced in the same cycle.
module dataproc_linebuf_row
  import dataproc_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [PIX_W-1:0] wdata,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  // NOTE: storage arrays are deliberately left unreset; every slot is rewritten before it is used.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dataproc_linebuf.sv
// Streaming 3x3 window generator: buffers two rows and emits fully populated interior windows.
// Optional DATAPROC_LINEBUF_STATS_EN adds frame_cnt / drop_cnt statistics outputs.
module dataproc_linebuf
  import dataproc_pkg::*;
#(
  parameter int IMG_W = 32,
  parameter int IMG_H = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIN_W-1:0] m_win,
  output logic             m_last
`ifdef DATAPROC_LINEBUF_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      drop_cnt
`endif
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] C_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] R_LAST = RW'(IMG_H - 1);

  state_t            state, state_nx;
  logic [RW-1:0]     r, r_nx, cur_r;
  logic [CW-1:0]     c, c_nx, cur_c;
  logic              accept, process, drop, frame_end, win_en;
  logic [PIX_W-1:0]  lb0_rd, lb1_rd;
  logic [COL_W-1:0]  col_new, col_m1, col_m2;

  // Single output register: accept whenever it is empty or being drained this cycle.
  assign s_ready = !reset && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    state_nx  = state;
    r_nx      = r;
    c_nx      = c;
    cur_r     = s_sof ? '0 : r;
    cur_c     = s_sof ? '0 : c;
    process   = 1'b0;
    drop      = 1'b0;
    frame_end = 1'b0;

    if (accept) begin
      if (state == IDLE && !s_sof) drop = 1'b1;
      else                         process = 1'b1;
    end

    if (process) begin
      state_nx = RUN;
      if (cur_c == C_LAST) begin
        c_nx = '0;
        if (cur_r == R_LAST) begin
          r_nx      = '0;
          state_nx  = IDLE;
          frame_end = 1'b1;
        end else begin
          r_nx = cur_r + RW'(1);
        end
      end else begin
        c_nx = cur_c + CW'(1);
        r_nx = cur_r;
      end
    end
  end

  assign win_en = process && (cur_r >= RW'(2)) && (cur_c >= CW'(2));

  dataproc_linebuf_row #(.DEPTH(IMG_W), .AW(CW)) u_lb0 (
    .clk   (clk),
    .we    (process),
    .addr  (cur_c),
    .wdata (s_data),
    .rdata (lb0_rd)
  );

  // Row r-1 ages into row r-2 as its slot is overwritten by the new pixel.
  dataproc_linebuf_row #(.DEPTH(IMG_W), .AW(CW)) u_lb1 (
    .clk   (clk),
    .we    (process),
    .addr  (cur_c),
    .wdata (lb0_rd),
    .rdata (lb1_rd)
  );

  assign col_new = {s_data, lb0_rd, lb1_rd};

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      r       <= '0;
      c       <= '0;
      m_valid <= 1'b0;
      m_win   <= '0;
      m_last  <= 1'b0;
    end else begin
      state <= state_nx;
      r     <= r_nx;
      c     <= c_nx;
      if (win_en) begin
        m_valid <= 1'b1;
        m_win   <= pack_window(col_m2, col_m1, col_new);
        m_last  <= frame_end;
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Column history only matters once two same-row columns have been shifted in.
  always_ff @(posedge clk) begin
    if (process) begin
      col_m1 <= col_new;
      col_m2 <= col_m1;
    end
  end

`ifdef DATAPROC_LINEBUF_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      if (drop)      drop_cnt  <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dataproc_linebuf.sv
// Self-checking bench for dataproc_linebuf on a 4x4 image: per-pixel vector table plus a
// frame-store scoreboard for stalls, mid-frame restarts, reset and back-to-back frames.
module tb_dataproc_linebuf;

  localparam int W = 4;
  localparam int H = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_sof = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        m_ready = 1'b0;
  logic        s_ready, m_valid, m_last;
  logic [71:0] m_win;
`ifdef DATAPROC_LINEBUF_STATS_EN
  logic [15:0] frame_cnt, drop_cnt;
`endif

  always #5 clk = ~clk;

  dataproc_linebuf #(.IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_sof     (s_sof),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_win     (m_win),
    .m_last    (m_last)
`ifdef DATAPROC_LINEBUF_STATS_EN
    ,
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
`endif
  );

  typedef struct {
    logic [7:0]  data;
    logic        sof;
    logic        exp_valid;
    logic [71:0] exp_win;
    logic        exp_last;
  } vec_t;

  typedef struct {
    logic [71:0] win;
    logic        last;
  } exp_t;

  vec_t       vecs [16];
  exp_t       exp_q [$];
  logic [7:0] stim_data [$];
  logic       stim_sof [$];

  int checks = 0;
  int failures = 0;
  int win_cnt, last_cnt, acc_cnt, new_cnt, stream_cycles;

  // Frame-store reference model
  bit         m_run = 1'b0;
  int         mr = 0;
  int         mc = 0;
  logic [7:0] img [H][W];

  task automatic check(input bit ok, input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [71:0] model_win();
    logic [71:0] w;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[8*(3*i+j) +: 8] = img[mr-2+i][mc-2+j];
    return w;
  endfunction

  task automatic model_accept(input logic [7:0] d, input logic sof);
    exp_t e;
    if (sof) begin
      m_run = 1'b1;
      mr = 0;
      mc = 0;
    end
    if (m_run) begin
      img[mr][mc] = d;
      if (mr >= 2 && mc >= 2) begin
        e.win  = model_win();
        e.last = (mr == H-1) && (mc == W-1);
        exp_q.push_back(e);
      end
      if (mc == W-1) begin
        mc = 0;
        if (mr == H-1) begin
          mr = 0;
          m_run = 1'b0;
        end else begin
          mr++;
        end
      end else begin
        mc++;
      end
    end
  endtask

  task automatic push_frame(input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      stim_data.push_back(base + 8'((k / W) * 16 + (k % W)));
      stim_sof.push_back(k == 0);
    end
  endtask

  task automatic clear_model();
    m_run = 1'b0;
    mr = 0;
    mc = 0;
    exp_q.delete();
    stim_data.delete();
    stim_sof.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    s_sof = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    clear_model();
  endtask

  // Drives queued pixels, compares every presented window against the scoreboard head.
  task automatic run_stream(input bit toggle, input int budget);
    int  cyc;
    bit  done;
    done = 1'b0;
    win_cnt = 0;
    last_cnt = 0;
    acc_cnt = 0;
    new_cnt = 0;
    for (cyc = 0; cyc < budget && !done; cyc++) begin
      m_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      if (stim_data.size() > 0) begin
        s_valid = 1'b1;
        s_data  = stim_data[0];
        s_sof   = stim_sof[0];
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
      end
      @(negedge clk);
      check(m_valid == (exp_q.size() > 0), "valid_vs_scoreboard", 72'(m_valid), 72'(exp_q.size() > 0));
      if (m_valid && exp_q.size() > 0) begin
        check(m_win == exp_q[0].win, "window", m_win, exp_q[0].win);
        check(m_last == exp_q[0].last, "last", 72'(m_last), 72'(exp_q[0].last));
        if (m_ready) begin
          win_cnt++;
          if (m_last) last_cnt++;
          if (m_win[71]) new_cnt++;
          void'(exp_q.pop_front());
        end
      end
      if (s_valid && s_ready) begin
        model_accept(s_data, s_sof);
        void'(stim_data.pop_front());
        void'(stim_sof.pop_front());
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      if (stim_data.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    stream_cycles = cyc;
    if (!done) check(1'b0, "stream_timeout", 72'(cyc), 72'(budget));
    else       check(m_valid == 1'b0, "drained_valid", 72'(m_valid), 72'd0);
  endtask

  initial begin
    // Reset state while reset is held high
    repeat (2) @(posedge clk);
    #1;
    check(s_ready == 1'b0, "reset_s_ready", 72'(s_ready), 72'd0);
    check(m_valid == 1'b0, "reset_m_valid", 72'(m_valid), 72'd0);
    check(m_win == 72'd0, "reset_m_win", m_win, 72'd0);
    check(m_last == 1'b0, "reset_m_last", 72'(m_last), 72'd0);
    reset = 1'b0;

    // Vector table: one 4x4 frame, pixel (r,c) = r*16+c, m_ready held high
    for (int k = 0; k < 16; k++) begin
      vecs[k].data      = 8'((k / W) * 16 + (k % W));
      vecs[k].sof       = (k == 0);
      vecs[k].exp_valid = 1'b0;
      vecs[k].exp_win   = '0;
      vecs[k].exp_last  = 1'b0;
    end
    vecs[10].exp_valid = 1'b1; vecs[10].exp_win = 72'h22_21_20_12_11_10_02_01_00;
    vecs[11].exp_valid = 1'b1; vecs[11].exp_win = 72'h23_22_21_13_12_11_03_02_01;
    vecs[14].exp_valid = 1'b1; vecs[14].exp_win = 72'h32_31_30_22_21_20_12_11_10;
    vecs[15].exp_valid = 1'b1; vecs[15].exp_win = 72'h33_32_31_23_22_21_13_12_11;
    vecs[15].exp_last  = 1'b1;

    m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s_valid = 1'b1;
      s_data  = vecs[k].data;
      s_sof   = vecs[k].sof;
      @(posedge clk);
      #1;
      check(m_valid == vecs[k].exp_valid, "t1_valid", 72'(m_valid), 72'(vecs[k].exp_valid));
      if (vecs[k].exp_valid) begin
        check(m_win == vecs[k].exp_win, "t1_win", m_win, vecs[k].exp_win);
        check(m_last == vecs[k].exp_last, "t1_last", 72'(m_last), 72'(vecs[k].exp_last));
      end
    end
    s_valid = 1'b0;
    s_sof = 1'b0;
    @(posedge clk);
    #1;
    check(m_valid == 1'b0, "t1_drain", 72'(m_valid), 72'd0);

    // Same frame with m_ready toggling every cycle
    push_frame(8'h00, 16);
    run_stream(1'b1, 200);
    check(win_cnt == 4, "t2_windows", 72'(win_cnt), 72'd4);
    check(last_cnt == 1, "t2_lasts", 72'(last_cnt), 72'd1);
    check(acc_cnt == 16, "t2_accepts", 72'(acc_cnt), 72'd16);

    // Five pixels without SOF after reset: accepted and discarded
    do_reset();
    for (int k = 0; k < 5; k++) begin
      stim_data.push_back(8'(8'hA0 + k));
      stim_sof.push_back(1'b0);
    end
    run_stream(1'b0, 50);
    check(acc_cnt == 5, "t3_accepts", 72'(acc_cnt), 72'd5);
    check(win_cnt == 0, "t3_windows", 72'(win_cnt), 72'd0);
`ifdef DATAPROC_LINEBUF_STATS_EN
    check(drop_cnt == 16'd5, "t3_drop_cnt", 72'(drop_cnt), 72'd5);
`endif

    // SOF reasserted at (3,1) of a running frame, then a full new frame
    push_frame(8'h00, 13);
    push_frame(8'h80, 16);
    run_stream(1'b0, 200);
    check(win_cnt == 6, "t4_windows_total", 72'(win_cnt), 72'd6);
    check(new_cnt == 4, "t4_windows_new", 72'(new_cnt), 72'd4);
    check(last_cnt == 1, "t4_lasts", 72'(last_cnt), 72'd1);

    // Reset while a window is stalled on the output
    do_reset();
    push_frame(8'h00, 10);
    run_stream(1'b0, 100);
    m_ready = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'h22;
    s_sof   = 1'b0;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    check(m_valid == 1'b1, "t5_stalled_valid", 72'(m_valid), 72'd1);
    check(m_win == 72'h22_21_20_12_11_10_02_01_00, "t5_stalled_win", m_win, 72'h22_21_20_12_11_10_02_01_00);
    check(s_ready == 1'b0, "t5_stalled_ready", 72'(s_ready), 72'd0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check(m_valid == 1'b0, "t5_reset_valid", 72'(m_valid), 72'd0);
    check(m_win == 72'd0, "t5_reset_win", m_win, 72'd0);
    reset = 1'b0;
    clear_model();
    push_frame(8'h40, 16);
    run_stream(1'b0, 200);
    check(win_cnt == 4, "t5_windows", 72'(win_cnt), 72'd4);
    check(last_cnt == 1, "t5_lasts", 72'(last_cnt), 72'd1);

    // Three back-to-back frames at full throughput
    do_reset();
    push_frame(8'h00, 16);
    push_frame(8'h40, 16);
    push_frame(8'h80, 16);
    run_stream(1'b0, 300);
    check(win_cnt == 12, "t6_windows", 72'(win_cnt), 72'd12);
    check(last_cnt == 3, "t6_lasts", 72'(last_cnt), 72'd3);
    check(acc_cnt == 48, "t6_accepts", 72'(acc_cnt), 72'd48);
    check(stream_cycles == 49, "t6_throughput_cycles", 72'(stream_cycles), 72'd49);
`ifdef DATAPROC_LINEBUF_STATS_EN
    check(frame_cnt == 16'd3, "t6_frame_cnt", 72'(frame_cnt), 72'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
